// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store read-modify-write unit.
//   funct3_e  - RV32I load/store size/sign encodings
//   state_e   - lsu_rmw FSM states
//   lane masks and helpers used to pick the byte lane of an access
package lsu_pkg;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_e;

  localparam int BYTE_BITS = 8;
  localparam int HALF_BITS = 16;

  // Which low address bits survive for lane selection at each access size.
  localparam logic [1:0] BYTE_LANE_MASK = 2'b11;
  localparam logic [1:0] HALF_LANE_MASK = 2'b10;
  localparam logic [1:0] WORD_LANE_MASK = 2'b00;

  function automatic logic funct3_defined(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic [1:0] lane_mask(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return BYTE_LANE_MASK;
      F3_H, F3_HU: return HALF_LANE_MASK;
      default:     return WORD_LANE_MASK;
    endcase
  endfunction

  // Only halves and words can be misaligned; undefined encodings never trap.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    case (f3)
      F3_H, F3_HU, F3_W: return (addr_lo & ~lane_mask(f3)) != 2'b00;
      default:           return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_rmw_if.sv
// lsu_rmw_if: pipeline request/response and data-memory signals of lsu_rmw.
//   master - pipeline and memory side (drives requests and mem_rd)
//   slave  - the LSU (drives ready/response and memory write port)
// exc_valid/exc_addr exist only when LSU_MISALIGN_TRAP_EN is defined.
interface lsu_rmw_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) ();
  logic                     req_valid;
  logic                     req_ready;
  logic                     req_we;
  logic [2:0]               req_funct3;
  logic [ADDRESS_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0]    req_wdata;
  logic                     resp_valid;
  logic [DATA_WIDTH-1:0]    resp_rdata;
  logic                     mem_we;
  logic [ADDRESS_WIDTH-1:0] mem_a;
  logic [DATA_WIDTH-1:0]    mem_wd;
  logic [DATA_WIDTH-1:0]    mem_rd;
`ifdef LSU_MISALIGN_TRAP_EN
  logic                     exc_valid;
  logic [ADDRESS_WIDTH-1:0] exc_addr;
`endif

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
    input  req_ready, resp_valid, resp_rdata, mem_we, mem_a, mem_wd
`ifdef LSU_MISALIGN_TRAP_EN
    , input exc_valid, exc_addr
`endif
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
    output req_ready, resp_valid, resp_rdata, mem_we, mem_a, mem_wd
`ifdef LSU_MISALIGN_TRAP_EN
    , output exc_valid, exc_addr
`endif
  );
endinterface

// File: rtl/lsu_align.sv
// lsu_align: combinational lane logic for lsu_rmw.
//   funct3    - access size/sign
//   addr_lo   - byte offset within the word
//   rd        - memory word read data
//   wd_lo     - low half of the right-aligned store data
//   load_data - extracted and extended load result (0 for undefined funct3)
//   merged    - rd with the store lane replaced (rd unchanged for word/undefined)
// Offset bits below the natural alignment are ignored, so a misaligned half or
// word is treated as its aligned container.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            funct3,
  input  logic [1:0]            addr_lo,
  input  logic [DATA_WIDTH-1:0] rd,
  input  logic [HALF_BITS-1:0]  wd_lo,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic [DATA_WIDTH-1:0] merged
);
  logic [1:0]            lane;
  logic [4:0]            shamt;
  logic [BYTE_BITS-1:0]  byte_sel;
  logic [HALF_BITS-1:0]  half_sel;
  logic [DATA_WIDTH-1:0] mask;
  logic [DATA_WIDTH-1:0] ins;

  always_comb begin
    lane      = addr_lo & lane_mask(funct3);
    shamt     = {lane, 3'b000};
    byte_sel  = rd[shamt +: BYTE_BITS];
    half_sel  = rd[shamt +: HALF_BITS];
    load_data = '0;
    mask      = '0;
    ins       = '0;
    case (funct3)
      F3_B:  load_data = {{(DATA_WIDTH-BYTE_BITS){byte_sel[BYTE_BITS-1]}}, byte_sel};
      F3_BU: load_data = {{(DATA_WIDTH-BYTE_BITS){1'b0}}, byte_sel};
      F3_H:  load_data = {{(DATA_WIDTH-HALF_BITS){half_sel[HALF_BITS-1]}}, half_sel};
      F3_HU: load_data = {{(DATA_WIDTH-HALF_BITS){1'b0}}, half_sel};
      F3_W:  load_data = rd;
      default: load_data = '0;
    endcase
    case (funct3)
      F3_B, F3_BU: begin
        mask = {{(DATA_WIDTH-BYTE_BITS){1'b0}}, {BYTE_BITS{1'b1}}} << shamt;
        ins  = {{(DATA_WIDTH-BYTE_BITS){1'b0}}, wd_lo[BYTE_BITS-1:0]} << shamt;
      end
      F3_H, F3_HU: begin
        mask = {{(DATA_WIDTH-HALF_BITS){1'b0}}, {HALF_BITS{1'b1}}} << shamt;
        ins  = {{(DATA_WIDTH-HALF_BITS){1'b0}}, wd_lo} << shamt;
      end
      default: begin
        mask = '0;
        ins  = '0;
      end
    endcase
    merged = (rd & ~mask) | (ins & mask);
  end
endmodule

// File: rtl/lsu_rmw.sv
// lsu_rmw: load/store unit for a word-wide data memory with combinational read.
// Word stores write in the accepting cycle; byte/half stores read the word,
// merge the lane and write it back one cycle later while stalling the pipeline.
//   clk, rst - clock, synchronous active-high reset
//   bus      - lsu_rmw_if.slave: req_*/resp_* pipeline side, mem_* memory side
// Optional: LSU_MISALIGN_TRAP_EN adds misaligned-access trapping (exc_valid/
// exc_addr); without it misaligned halves/words access the aligned container.
//
// state    | meaning
// ST_IDLE  | ready; loads and word stores complete, byte/half store captured
// ST_WRITE | write back merged word, pipeline stalled
module lsu_rmw
  import lsu_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input logic      clk,
  input logic      rst,
  lsu_rmw_if.slave bus
);
  state_e                   state;
  logic                     resp_valid_q;
  logic [DATA_WIDTH-1:0]    resp_rdata_q;
  logic [DATA_WIDTH-1:0]    wr_word_q;
  logic [ADDRESS_WIDTH-1:0] wr_idx_q;
  logic [ADDRESS_WIDTH-1:0] req_idx;
  logic [DATA_WIDTH-1:0]    load_data;
  logic [DATA_WIDTH-1:0]    merged;
  logic accept, f3_defined, misal;
  logic take_load, take_word_store, take_sub_store;
`ifdef LSU_MISALIGN_TRAP_EN
  logic                     exc_valid_q;
  logic [ADDRESS_WIDTH-1:0] exc_addr_q;
`endif

  assign req_idx    = {2'b00, bus.req_addr[ADDRESS_WIDTH-1:2]};
  assign accept     = bus.req_valid && (state == ST_IDLE);
  assign f3_defined = funct3_defined(bus.req_funct3);
`ifdef LSU_MISALIGN_TRAP_EN
  assign misal      = misaligned(bus.req_funct3, bus.req_addr[1:0]);
`else
  assign misal      = 1'b0;
`endif

  // Undefined encodings: loads still respond (with zero), stores are dropped.
  assign take_load       = accept && !bus.req_we && !misal;
  assign take_word_store = accept && bus.req_we && !misal && (bus.req_funct3 == F3_W);
  assign take_sub_store  = accept && bus.req_we && !misal && f3_defined &&
                           (bus.req_funct3 != F3_W);

  lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .funct3    (bus.req_funct3),
    .addr_lo   (bus.req_addr[1:0]),
    .rd        (bus.mem_rd),
    .wd_lo     (bus.req_wdata[HALF_BITS-1:0]),
    .load_data (load_data),
    .merged    (merged)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      wr_word_q    <= '0;
      wr_idx_q     <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      exc_valid_q  <= 1'b0;
      exc_addr_q   <= '0;
`endif
    end else begin
      resp_valid_q <= take_load;
      if (take_load) resp_rdata_q <= load_data;
`ifdef LSU_MISALIGN_TRAP_EN
      exc_valid_q <= accept && misal;
      if (accept && misal) exc_addr_q <= bus.req_addr;
`endif
      case (state)
        ST_IDLE: begin
          if (take_sub_store) begin
            wr_word_q <= merged;
            wr_idx_q  <= req_idx;
            state     <= ST_WRITE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (state == ST_IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  // Gated by rst so a reset landing in WRITE suppresses the pending write.
  assign bus.mem_we     = !rst && ((state == ST_WRITE) || take_word_store);
  assign bus.mem_a      = (state == ST_WRITE) ? wr_idx_q : req_idx;
  assign bus.mem_wd     = (state == ST_WRITE) ? wr_word_q : bus.req_wdata;
`ifdef LSU_MISALIGN_TRAP_EN
  assign bus.exc_valid  = exc_valid_q;
  assign bus.exc_addr   = exc_addr_q;
`endif
endmodule

// File: tb/tb_lsu_rmw.sv
module tb_lsu_rmw;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [31:0] BASE = 32'h0004_0000;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef struct {
    logic        rdy0, we0;
    logic [31:0] a0, wd0;
    logic        rv1, we1, rdy1, ev1;
    logic [31:0] rd1, a1, wd1, ea1;
    int          waits;
    bit          timeout;
  } op_obs_t;

  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int failures = 0;
  logic [31:0] mem [16];
  logic [31:0] ref_mem [16];

  always #5 clk = ~clk;

  lsu_rmw_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  lsu_rmw #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  // Word memory window at indices 0x10000..0x1000F.
  assign bus.mem_rd = mem[bus.mem_a[3:0]];
  always @(posedge clk) if (bus.mem_we === 1'b1) mem[bus.mem_a[3:0]] <= bus.mem_wd;

  // ---------------- reference model ----------------
  function automatic int unsigned size_of(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic int unsigned lane_off(input logic [2:0] f3, input logic [31:0] addr);
    int unsigned sz, off;
    sz = size_of(f3);
    off = addr % 4;
    return (sz == 0) ? 0 : off - off % sz;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] word, input logic [2:0] f3,
                                             input logic [31:0] addr);
    int unsigned sz;
    longint unsigned v, span;
    sz = size_of(f3);
    if (sz == 0) return 32'h0;
    span = 64'd1 << (8 * sz);
    v = {32'h0, word} >> (8 * lane_off(f3, addr));
    v = v % span;
    if ((f3 == 3'b000 || f3 == 3'b001) && v >= span / 2) v = v + (64'd1 << 32) - span;
    return v[31:0];
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] word, input logic [2:0] f3,
                                              input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] w;
    int unsigned sz, off;
    w = word;
    sz = size_of(f3);
    off = lane_off(f3, addr);
    for (int k = 0; k < int'(sz); k++) w[8*(off+k) +: 8] = wd[8*k +: 8];
    return w;
  endfunction

  function automatic bit model_trap(input logic [2:0] f3, input logic [31:0] addr);
    int unsigned sz;
    sz = size_of(f3);
    return TRAP_EN && (sz == 2 || sz == 4) && (addr % sz != 0);
  endfunction

  // ---------------- stimulus driver (observes only) ----------------
  task automatic drive_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output op_obs_t o);
    o = '{default: '0};
    @(negedge clk);
    while (bus.req_ready !== 1'b1 && o.waits < 16) begin
      @(negedge clk);
      o.waits++;
    end
    o.timeout = (bus.req_ready !== 1'b1);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr = addr; bus.req_wdata = wd;
    #1;
    o.rdy0 = bus.req_ready; o.we0 = bus.mem_we; o.a0 = bus.mem_a; o.wd0 = bus.mem_wd;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    #1;
    o.rv1 = bus.resp_valid; o.rd1 = bus.resp_rdata; o.we1 = bus.mem_we;
    o.a1 = bus.mem_a; o.wd1 = bus.mem_wd; o.rdy1 = bus.req_ready;
`ifdef LSU_MISALIGN_TRAP_EN
    o.ev1 = bus.exc_valid; o.ea1 = bus.exc_addr;
`endif
  endtask

  task automatic set_word(input int i, input logic [31:0] v);
    mem[i] = v;
    ref_mem[i] = v;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b010;
    bus.req_addr = BASE; bus.req_wdata = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.mem_we !== 1'b0) begin failures++; $display("FAIL rst_mem_we_gate: got %b expected 0", bus.mem_we); end
    bus.req_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", bus.req_ready); end
    checks++;
    if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid: got %b expected 0", bus.resp_valid); end
    checks++;
    if (bus.resp_rdata !== 32'h0) begin failures++; $display("FAIL reset_resp_rdata: got %h expected 0", bus.resp_rdata); end
    checks++;
    if (bus.mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we: got %b expected 0", bus.mem_we); end
    checks++;
    if (mem[0] !== 32'h0) begin failures++; $display("FAIL reset_no_write: got %h expected 0", mem[0]); end
  endtask

  task automatic test_directed();
    op_obs_t o;
    set_word(0, 32'h1122_3344);
    drive_op(1'b0, 3'b000, 32'h0004_0003, 32'h0, o);
    checks++;
    if (o.rv1 !== 1'b1 || o.rd1 !== 32'h0000_0011) begin failures++; $display("FAIL lb_0x40003: got v=%b %h expected v=1 00000011", o.rv1, o.rd1); end
    drive_op(1'b0, 3'b100, 32'h0004_0001, 32'h0, o);
    checks++;
    if (o.rv1 !== 1'b1 || o.rd1 !== 32'h0000_0033) begin failures++; $display("FAIL lbu_0x40001: got v=%b %h expected v=1 00000033", o.rv1, o.rd1); end
    set_word(0, 32'h8000_FF7F);
    drive_op(1'b0, 3'b001, 32'h0004_0000, 32'h0, o);
    checks++;
    if (o.rd1 !== 32'hFFFF_FF7F) begin failures++; $display("FAIL lh_0x40000: got %h expected ffffff7f", o.rd1); end
    drive_op(1'b0, 3'b101, 32'h0004_0002, 32'h0, o);
    checks++;
    if (o.rd1 !== 32'h0000_8000) begin failures++; $display("FAIL lhu_0x40002: got %h expected 00008000", o.rd1); end
    set_word(0, 32'hAABB_CCDD);
    drive_op(1'b1, 3'b000, 32'h0004_0001, 32'h0000_0012, o);
    checks++;
    if (o.we0 !== 1'b0 || o.rdy1 !== 1'b0) begin failures++; $display("FAIL sb_stall: got we0=%b rdy1=%b expected we0=0 rdy1=0", o.we0, o.rdy1); end
    checks++;
    if (o.we1 !== 1'b1 || o.a1 !== 32'h0001_0000 || o.wd1 !== 32'hAABB_12DD) begin
      failures++; $display("FAIL sb_write: got we=%b a=%h wd=%h expected we=1 a=00010000 wd=aabb12dd", o.we1, o.a1, o.wd1);
    end
    checks++;
    if (o.rv1 !== 1'b0) begin failures++; $display("FAIL sb_no_resp: got %b expected 0", o.rv1); end
    drive_op(1'b0, 3'b010, 32'h0004_0000, 32'h0, o);
    checks++;
    if (o.waits != 1) begin failures++; $display("FAIL sb_stall_len: got %0d expected 1", o.waits); end
    checks++;
    if (o.rd1 !== 32'hAABB_12DD) begin failures++; $display("FAIL lw_after_sb: got %h expected aabb12dd", o.rd1); end
    drive_op(1'b1, 3'b010, 32'h0004_0004, 32'hDEAD_BEEF, o);
    checks++;
    if (o.we0 !== 1'b1 || o.a0 !== 32'h0001_0001 || o.wd0 !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL sw_same_cycle: got we=%b a=%h wd=%h expected we=1 a=00010001 wd=deadbeef", o.we0, o.a0, o.wd0);
    end
    checks++;
    if (o.rdy1 !== 1'b1 || o.we1 !== 1'b0 || o.rv1 !== 1'b0) begin
      failures++; $display("FAIL sw_no_stall: got rdy=%b we=%b rv=%b expected 1 0 0", o.rdy1, o.we1, o.rv1);
    end
    drive_op(1'b1, 3'b001, 32'h0004_0004, 32'h0000_5678, o);
    checks++;
    if (o.waits != 0 || o.wd1 !== 32'hDEAD_5678 || o.a1 !== 32'h0001_0001) begin
      failures++; $display("FAIL sh_after_sw: got waits=%0d wd=%h a=%h expected 0 dead5678 00010001", o.waits, o.wd1, o.a1);
    end
    drive_op(1'b1, 3'b111, 32'h0004_0004, 32'h1111_1111, o);
    checks++;
    if (o.we0 !== 1'b0 || o.we1 !== 1'b0 || o.rdy1 !== 1'b1) begin
      failures++; $display("FAIL undef_store: got we0=%b we1=%b rdy=%b expected 0 0 1", o.we0, o.we1, o.rdy1);
    end
    drive_op(1'b0, 3'b011, 32'h0004_0004, 32'h0, o);
    checks++;
    if (o.rv1 !== 1'b1 || o.rd1 !== 32'h0) begin failures++; $display("FAIL undef_load: got v=%b %h expected v=1 0", o.rv1, o.rd1); end
    checks++;
    if (mem[1] !== 32'hDEAD_5678) begin failures++; $display("FAIL mem_after_undef: got %h expected dead5678", mem[1]); end
  endtask

  task automatic test_store_reset();
    op_obs_t o;
    set_word(2, 32'h0102_0304);
    drive_op(1'b0, 3'b010, 32'h0004_0008, 32'h0, o);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b001;
    bus.req_addr = 32'h0004_000A; bus.req_wdata = 32'h0000_BEEF;
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    #1;
    checks++;
    if (bus.mem_we !== 1'b0) begin failures++; $display("FAIL rst_in_write_we: got %b expected 0", bus.mem_we); end
    @(negedge clk);
    checks++;
    if (bus.mem_we !== 1'b0) begin failures++; $display("FAIL rst_in_write_we_mid: got %b expected 0", bus.mem_we); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 1'b1 || bus.mem_we !== 1'b0) begin
      failures++; $display("FAIL rst_to_idle: got rdy=%b we=%b expected 1 0", bus.req_ready, bus.mem_we);
    end
    checks++;
    if (bus.resp_rdata !== 32'h0 || bus.resp_valid !== 1'b0) begin
      failures++; $display("FAIL rst_resp_clear: got v=%b %h expected v=0 0", bus.resp_valid, bus.resp_rdata);
    end
    @(posedge clk);
    #1;
    checks++;
    if (mem[2] !== 32'h0102_0304) begin failures++; $display("FAIL rst_mem_unchanged: got %h expected 01020304", mem[2]); end
  endtask

  task automatic test_misalign();
    op_obs_t o;
    set_word(0, 32'hCAFE_F00D);
    drive_op(1'b0, 3'b010, 32'h0004_0002, 32'h0, o);
    checks++;
    if (o.we0 !== 1'b0) begin failures++; $display("FAIL misalign_lw_we: got %b expected 0", o.we0); end
    if (TRAP_EN) begin
      checks++;
      if (o.ev1 !== 1'b1 || o.ea1 !== 32'h0004_0002 || o.rv1 !== 1'b0) begin
        failures++; $display("FAIL misalign_trap: got ev=%b ea=%h rv=%b expected 1 00040002 0", o.ev1, o.ea1, o.rv1);
      end
    end else begin
      checks++;
      if (o.rv1 !== 1'b1 || o.rd1 !== 32'hCAFE_F00D) begin
        failures++; $display("FAIL misalign_forced: got v=%b %h expected v=1 cafef00d", o.rv1, o.rd1);
      end
    end
    drive_op(1'b1, 3'b001, 32'h0004_0003, 32'h0000_1234, o);
    checks++;
    if (o.we1 !== !TRAP_EN || o.rdy1 !== TRAP_EN) begin
      failures++; $display("FAIL misalign_sh: got we1=%b rdy1=%b expected %b %b", o.we1, o.rdy1, !TRAP_EN, TRAP_EN);
    end
    ref_mem[0] = model_trap(3'b001, 32'h0004_0003) ? ref_mem[0]
               : model_store(ref_mem[0], 3'b001, 32'h0004_0003, 32'h0000_1234);
    @(posedge clk);
    #1;
    checks++;
    if (mem[0] !== ref_mem[0]) begin failures++; $display("FAIL misalign_sh_mem: got %h expected %h", mem[0], ref_mem[0]); end
  endtask

  task automatic test_random();
    op_obs_t o;
    logic we;
    logic [2:0] f3;
    logic [31:0] addr, wd, exp;
    int unsigned idx, sz;
    bit trap, sub;
    for (int i = 0; i < 16; i++) set_word(i, $urandom);
    for (int n = 0; n < 300; n++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      addr = BASE + 32'($urandom_range(0, 63));
      wd = $urandom;
      idx = (addr >> 2) - 32'h0001_0000;
      sz = size_of(f3);
      trap = model_trap(f3, addr);
      sub = we && (sz == 1 || sz == 2) && !trap;
      drive_op(we, f3, addr, wd, o);
      checks++;
      if (o.timeout) begin failures++; $display("FAIL rnd_ready_timeout: op %0d never accepted", n); end
      checks++;
      if (o.a0 !== (addr >> 2)) begin failures++; $display("FAIL rnd_mem_a: op %0d got %h expected %h", n, o.a0, addr >> 2); end
      checks++;
      if (o.we0 !== (we && sz == 4 && !trap)) begin failures++; $display("FAIL rnd_we0: op %0d got %b", n, o.we0); end
      if (we && sz == 4 && !trap) begin
        checks++;
        if (o.wd0 !== wd) begin failures++; $display("FAIL rnd_sw_wd: op %0d got %h expected %h", n, o.wd0, wd); end
      end
      checks++;
      if (o.rv1 !== (!we && !trap)) begin failures++; $display("FAIL rnd_resp_valid: op %0d got %b expected %b", n, o.rv1, !we && !trap); end
      if (!we && !trap) begin
        exp = model_load(ref_mem[idx], f3, addr);
        checks++;
        if (o.rd1 !== exp) begin failures++; $display("FAIL rnd_load: op %0d f3=%b addr=%h got %h expected %h", n, f3, addr, o.rd1, exp); end
      end
      checks++;
      if (o.we1 !== sub || o.rdy1 !== !sub) begin failures++; $display("FAIL rnd_write_phase: op %0d got we=%b rdy=%b expected %b %b", n, o.we1, o.rdy1, sub, !sub); end
      if (sub) begin
        exp = model_store(ref_mem[idx], f3, addr, wd);
        checks++;
        if (o.a1 !== (addr >> 2) || o.wd1 !== exp) begin
          failures++; $display("FAIL rnd_rmw: op %0d got a=%h wd=%h expected a=%h wd=%h", n, o.a1, o.wd1, addr >> 2, exp);
        end
      end
      if (TRAP_EN) begin
        checks++;
        if (o.ev1 !== trap || (trap && o.ea1 !== addr)) begin
          failures++; $display("FAIL rnd_exc: op %0d got ev=%b ea=%h expected ev=%b ea=%h", n, o.ev1, o.ea1, trap, addr);
        end
      end
      if (we && sz != 0 && !trap) ref_mem[idx] = model_store(ref_mem[idx], f3, addr, wd);
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (mem[i] !== ref_mem[i]) begin failures++; $display("FAIL rnd_final_mem[%0d]: got %h expected %h", i, mem[i], ref_mem[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] f3s [5];
    logic [2:0] f3;
    logic [31:0] addr, exp;
    int unsigned idx, sz, off;
    f3s[0] = 3'b000; f3s[1] = 3'b001; f3s[2] = 3'b010; f3s[3] = 3'b100; f3s[4] = 3'b101;
    for (int i = 0; i < 16; i++) set_word(i, $urandom);
    @(negedge clk);
    for (int n = 0; n < 12; n++) begin
      f3 = f3s[$urandom_range(0, 4)];
      sz = size_of(f3);
      idx = $urandom_range(0, 15);
      off = $urandom_range(0, 3);
      addr = BASE + 32'(idx * 4 + off - off % sz);
      exp = model_load(ref_mem[idx], f3, addr);
      bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = f3; bus.req_addr = addr;
      #1;
      checks++;
      if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready: load %0d got %b expected 1", n, bus.req_ready); end
      @(posedge clk);
      #1;
      checks++;
      if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== exp) begin
        failures++; $display("FAIL b2b_resp: load %0d got v=%b %h expected v=1 %h", n, bus.resp_valid, bus.resp_rdata, exp);
      end
    end
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL b2b_trailing_resp: got %b expected 0", bus.resp_valid); end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
    bus.req_addr = BASE; bus.req_wdata = 32'h0;
    for (int i = 0; i < 16; i++) set_word(i, 32'h0);
    test_reset();
    test_directed();
    test_store_reset();
    test_misalign();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
